// File: rtl/audio_i2s_tx_if.sv
// Stereo sample handshake between the mixer/filter stage and the I2S transmitter.
// The transmitter uses the slave modport; the upstream stage uses master.
interface audio_i2s_tx_if #(
   parameter int DW = 16
);
   logic          sample_valid;
   logic          sample_ready;
   logic [DW-1:0] sample_l;
   logic [DW-1:0] sample_r;

   modport master (output sample_valid, sample_l, sample_r, input sample_ready);
   modport slave  (input sample_valid, sample_l, sample_r, output sample_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// Single-clock I2S transmitter: stereo-pair FIFO, prefill/run frame scheduler and serializer.
// Define AUDIO_I2S_TX_LEFT_JUSTIFIED_EN for left-justified output instead of standard I2S.
module audio_i2s_tx #(
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk_audio,
   input  logic                         reset_n,
   audio_i2s_tx_if.slave                up,
   output logic                         audio_sclk,
   output logic                         audio_lrck,
   output logic                         audio_dac,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [7:0]                   underrun_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_HALF = LW'(FIFO_DEPTH / 2);

   typedef enum logic {PREFILL, RUN} state_t;

   state_t        state, state_next;
   logic [7:0]    c;
   logic [7:0]    cn;
   logic [5:0]    sn;
   logic [4:0]    hn;
   logic [15:0]   mem_l [FIFO_DEPTH];
   logic [15:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   pad_l, pad_r;
   logic [15:0]   hold_l, hold_r, hold_l_next, hold_r_next;
   logic [15:0]   word;
   logic          full, empty, push, pop, underrun, frame_end, dac_bit;

   // Narrow samples sit in the upper bits of the 16-bit word.
   assign pad_l = 16'(up.sample_l) << (16 - DW);
   assign pad_r = 16'(up.sample_r) << (16 - DW);

   assign full            = (fifo_level == LVL_FULL);
   assign empty           = (fifo_level == '0);
   assign up.sample_ready = !full;
   assign push            = up.sample_valid && !full;
   assign frame_end       = (c == 8'hFF);

   assign audio_sclk = c[1];
   assign audio_lrck = c[7];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) c <= '0;
      else          c <= c + 8'd1;
   end

   // NOTE: storage has no reset; the level counter alone decides which entries are valid.
   always_ff @(posedge clk_audio) begin
      if (push) begin
         mem_l[wr_ptr] <= pad_l;
         mem_r[wr_ptr] <= pad_r;
      end
   end

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) state <= PREFILL;
      else          state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      underrun   = 1'b0;
      if (frame_end) begin
         unique case (state)
            PREFILL: begin
               if (fifo_level >= LVL_HALF) begin
                  pop        = 1'b1;
                  state_next = RUN;
               end
            end
            RUN: begin
               if (empty) underrun = 1'b1;
               else       pop      = 1'b1;
            end
            default: state_next = PREFILL;
         endcase
      end
   end

   // Holding regs change only at the frame boundary, so they also serve as the frame words.
   assign hold_l_next = pop ? mem_l[rd_ptr] : hold_l;
   assign hold_r_next = pop ? mem_r[rd_ptr] : hold_r;

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) begin
         hold_l       <= '0;
         hold_r       <= '0;
         underrun_cnt <= '0;
      end else begin
         hold_l <= hold_l_next;
         hold_r <= hold_r_next;
         if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end
   end

   // The DAC bit for the upcoming SCLK period is computed from the next counter value.
   assign cn   = c + 8'd1;
   assign sn   = cn[7:2];
   assign hn   = sn[4:0];
   assign word = sn[5] ? hold_r_next : hold_l_next;

   always_comb begin
      dac_bit = 1'b0;
`ifdef AUDIO_I2S_TX_LEFT_JUSTIFIED_EN
      if (!hn[4]) dac_bit = word[4'd15 - hn[3:0]];
`else
      if (hn != 5'd0 && hn <= 5'd16) dac_bit = word[4'(5'd16 - hn)];
`endif
   end

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n)              audio_dac <= 1'b0;
      else if (cn[1:0] == 2'b00) audio_dac <= dac_bit;
   end

endmodule
